// File: rtl/airlock_chamber_ctrl_if.sv
// Port-state, request and tick inputs plus the chamber status outputs of the airlock sequencer.
interface airlock_chamber_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             tick;
  logic             arrive;
  logic             depart;
  logic             outer_closed;
  logic             inner_closed;
  logic             press_req;
  logic             evac_req;
  logic [2:0]       state;
  logic [CNT_W-1:0] countdown;
  logic             pressurized;
  logic             outer_open_ok;
  logic             inner_open_ok;
  logic             occupied;
  logic             err;

  modport master (
    output tick, arrive, depart, outer_closed, inner_closed, press_req, evac_req,
    input  state, countdown, pressurized, outer_open_ok, inner_open_ok, occupied, err
  );

  modport slave (
    input  tick, arrive, depart, outer_closed, inner_closed, press_req, evac_req,
    output state, countdown, pressurized, outer_open_ok, inner_open_ok, occupied, err
  );
endinterface

// File: rtl/airlock_chamber_ctrl.sv
// Airlock chamber sequencer: timed pressurize/evacuate cycles, port-open permissions,
// occupancy tracking and request rejection.
module airlock_chamber_ctrl #(
  parameter int unsigned PRESS_TICKS = 7,
  parameter int unsigned EVAC_TICKS  = 8,
  parameter int unsigned CNT_W       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  airlock_chamber_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_EVACUATED    = 3'd0,
    S_PRESSURIZING = 3'd1,
    S_PRESSURIZED  = 3'd2,
    S_EVACUATING   = 3'd3,
    S_FAULT        = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             occ_q, occ_d;
  logic             err_q, err_d;
  logic             ports_closed;
  logic             single_press;
  logic             single_evac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EVACUATED;
      cnt_q   <= '0;
      occ_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  // Every request flags err unless the current state explicitly accepts it below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    ports_closed = bus.outer_closed & bus.inner_closed;
    single_press = bus.press_req & ~bus.evac_req;
    single_evac  = bus.evac_req & ~bus.press_req;
    err_d        = bus.press_req | bus.evac_req;

    unique case (state_q)
      S_EVACUATED: begin
        if (bus.arrive && !bus.outer_closed) occ_d = 1'b1;
        if (single_press && ports_closed) begin
          state_d = S_PRESSURIZING;
          cnt_d   = CNT_W'(PRESS_TICKS);
          err_d   = 1'b0;
        end
      end
      S_PRESSURIZING, S_EVACUATING: begin
        // An open port aborts the cycle even if a tick lands in the same clock.
        if (!ports_closed) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (bus.tick && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = (state_q == S_PRESSURIZING) ? S_PRESSURIZED : S_EVACUATED;
          end
        end
      end
      S_PRESSURIZED: begin
        if (bus.depart && !bus.inner_closed) occ_d = 1'b0;
        if (single_evac && ports_closed) begin
          state_d = S_EVACUATING;
          cnt_d   = CNT_W'(EVAC_TICKS);
          err_d   = 1'b0;
        end
      end
      S_FAULT: begin
        if (single_evac && ports_closed) begin
          state_d = S_EVACUATING;
          cnt_d   = CNT_W'(EVAC_TICKS);
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_FAULT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.state         = 3'(state_q);
  assign bus.countdown     = cnt_q;
  assign bus.occupied      = occ_q;
  assign bus.err           = err_q;
  assign bus.pressurized   = (state_q == S_PRESSURIZED);
  assign bus.outer_open_ok = (state_q == S_EVACUATED);
  assign bus.inner_open_ok = (state_q == S_PRESSURIZED);

endmodule

// File: tb/tb_airlock_chamber_ctrl.sv
// Scoreboard bench for airlock_chamber_ctrl: directed scenarios then random traffic,
// all checked against a rule-level chamber model.
module tb_airlock_chamber_ctrl;

  localparam int unsigned PRESS = 7;
  localparam int unsigned EVAC  = 8;
  localparam int unsigned CW    = 4;

  localparam int P_EVACUATED    = 0;
  localparam int P_PRESSURIZING = 1;
  localparam int P_PRESSURIZED  = 2;
  localparam int P_EVACUATING   = 3;
  localparam int P_FAULT        = 4;

  typedef struct {
    int state;
    int countdown;
    int pressurized;
    int outer_ok;
    int inner_ok;
    int occupied;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  airlock_chamber_ctrl_if #(.CNT_W(CW)) bus ();

  airlock_chamber_ctrl #(
    .PRESS_TICKS(PRESS),
    .EVAC_TICKS (EVAC),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Chamber model: phase, ticks still owed, occupancy.
  int m_phase;
  int m_left;
  bit m_occ;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_EVACUATED;
    m_left  = 0;
    m_occ   = 1'b0;
  endfunction

  function automatic exp_t model_step(input bit tk, input bit ar, input bit dp,
                                      input bit oc, input bit ic, input bit pr, input bit er);
    exp_t e;
    bit   closed  = oc && ic;
    bit   acc_p   = pr && !er && closed && (m_phase == P_EVACUATED);
    bit   acc_e   = er && !pr && closed && (m_phase == P_PRESSURIZED || m_phase == P_FAULT);
    bit   running = (m_phase == P_PRESSURIZING || m_phase == P_EVACUATING);
    if (m_phase == P_EVACUATED && ar && !oc) m_occ = 1'b1;
    if (m_phase == P_PRESSURIZED && dp && !ic) m_occ = 1'b0;
    if (running) begin
      if (!closed) begin
        m_phase = P_FAULT;
        m_left  = 0;
      end else if (tk && m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = (m_phase == P_PRESSURIZING) ? P_PRESSURIZED : P_EVACUATED;
      end
    end else if (acc_p) begin
      m_phase = P_PRESSURIZING;
      m_left  = PRESS;
    end else if (acc_e) begin
      m_phase = P_EVACUATING;
      m_left  = EVAC;
    end
    e.state       = m_phase;
    e.countdown   = m_left;
    e.pressurized = (m_phase == P_PRESSURIZED) ? 1 : 0;
    e.outer_ok    = (m_phase == P_EVACUATED) ? 1 : 0;
    e.inner_ok    = (m_phase == P_PRESSURIZED) ? 1 : 0;
    e.occupied    = m_occ ? 1 : 0;
    e.err         = ((pr || er) && !acc_p && !acc_e) ? 1 : 0;
    return e;
  endfunction

  task automatic step(input bit tk, input bit ar, input bit dp,
                      input bit oc, input bit ic, input bit pr, input bit er);
    @(negedge clk);
    bus.tick         = tk;
    bus.arrive       = ar;
    bus.depart       = dp;
    bus.outer_closed = oc;
    bus.inner_closed = ic;
    bus.press_req    = pr;
    bus.evac_req     = er;
    exp_q.push_back(model_step(tk, ar, dp, oc, ic, pr, er));
  endtask

  task automatic idle(input bit oc, input bit ic, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, oc, ic, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Direct read of the DUT after the edge that consumed the last step.
  task automatic check_now(input string name, input int st, input int cd, input int er);
    @(posedge clk);
    #2;
    chk({name, ".state"}, int'(bus.state), st);
    chk({name, ".countdown"}, int'(bus.countdown), cd);
    chk({name, ".err"}, int'(bus.err), er);
  endtask

  task automatic reset_checks(input string name);
    chk({name, ".state"}, int'(bus.state), P_EVACUATED);
    chk({name, ".countdown"}, int'(bus.countdown), 0);
    chk({name, ".occupied"}, int'(bus.occupied), 0);
    chk({name, ".err"}, int'(bus.err), 0);
    chk({name, ".outer_ok"}, int'(bus.outer_open_ok), 1);
  endtask

  // Monitor: the DUT presents a new response every cycle; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb.state", int'(bus.state), e.state);
        chk("sb.countdown", int'(bus.countdown), e.countdown);
        chk("sb.pressurized", int'(bus.pressurized), e.pressurized);
        chk("sb.outer_open_ok", int'(bus.outer_open_ok), e.outer_ok);
        chk("sb.inner_open_ok", int'(bus.inner_open_ok), e.inner_ok);
        chk("sb.occupied", int'(bus.occupied), e.occupied);
        chk("sb.err", int'(bus.err), e.err);
      end
    end
  end

  initial begin
    bit tk, ar, dp, oc, ic, pr, er;
    rst_n            = 1'b0;
    bus.tick         = 1'b0;
    bus.arrive       = 1'b0;
    bus.depart       = 1'b0;
    bus.outer_closed = 1'b1;
    bus.inner_closed = 1'b1;
    bus.press_req    = 1'b0;
    bus.evac_req     = 1'b0;
    model_reset();
    #3;
    reset_checks("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full pressurize cycle with both ports closed.
    idle(1'b1, 1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_now("press_load", P_PRESSURIZING, PRESS, 0);
    ticks(PRESS);
    check_now("press_done", P_PRESSURIZED, 0, 0);
    chk("press_done.inner_ok", int'(bus.inner_open_ok), 1);
    chk("press_done.outer_ok", int'(bus.outer_open_ok), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(EVAC);
    idle(1'b1, 1'b1, 1);

    // press_req with outer open is rejected.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_now("press_open", P_EVACUATED, 0, 1);
    idle(1'b1, 1'b1, 2);

    // Port opens mid-pressurize, then recover through evacuation.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(PRESS - 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_now("fault", P_FAULT, 0, 0);
    chk("fault.outer_ok", int'(bus.outer_open_ok), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(EVAC);
    check_now("fault_recover", P_EVACUATED, 0, 0);

    // Tick coinciding with the load is ignored; simultaneous requests are rejected.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_now("load_tick", P_PRESSURIZING, PRESS, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_now("dual_req", P_PRESSURIZING, PRESS, 1);
    ticks(PRESS);

    // Occupancy: depart with inner open, arrive while pressurized is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(EVAC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(PRESS);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1);

    // Asynchronous reset in the middle of an evacuation with a boat aboard.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(EVAC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(PRESS);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(EVAC - 4);
    idle(1'b1, 1'b1, 1);
    @(negedge clk);
    chk("pre_reset.countdown", int'(bus.countdown), 4);
    chk("pre_reset.occupied", int'(bus.occupied), 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: ports mostly closed so full cycles complete.
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 1) == 0);
      ar = ($urandom_range(0, 5) == 0);
      dp = ($urandom_range(0, 5) == 0);
      oc = ($urandom_range(0, 15) != 0);
      ic = ($urandom_range(0, 15) != 0);
      pr = ($urandom_range(0, 6) == 0);
      er = ($urandom_range(0, 6) == 0);
      step(tk, ar, dp, oc, ic, pr, er);
    end
    idle(1'b1, 1'b1, 3);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
